// File: rtl/uart_tx_fifo_ctrl_if.sv
// Handshake/data bundle between the THR write side, the transmit FSM and the TX FIFO controller.
interface uart_tx_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);

  // Control and data driven into the FIFO controller
  logic                  fifo_en;
  logic                  tx_fifo_clr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  tsr_load;
  logic                  not_op;

  // Status and data returned by the FIFO controller
  logic [DATA_WIDTH-1:0] thr_data;
  logic                  thre;
  logic                  temt;
  logic [ADDR_WIDTH:0]   tx_level;
  logic                  tx_ovf;
  logic                  thre_evt;

  // Register file / transmit FSM side
  modport master (
    output fifo_en, tx_fifo_clr, wr_en, wr_data, tsr_load, not_op,
    input  thr_data, thre, temt, tx_level, tx_ovf, thre_evt
  );

  // FIFO controller side
  modport slave (
    input  fifo_en, tx_fifo_clr, wr_en, wr_data, tsr_load, not_op,
    output thr_data, thre, temt, tx_level, tx_ovf, thre_evt
  );

endinterface

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmit holding-register scheduler: FIFO (16550 FIFO mode) or single holding slot,
// first-word-fall-through head data, THRE/TEMT status, fill level, overrun and THRE event.
module uart_tx_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                pclk,
  input  logic                presetn,
  uart_tx_fifo_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  fifo_en_q;
  logic                  tx_ovf_q;
  logic                  thre_evt_q;
  logic                  temt_q;

  logic [CNT_W-1:0]      cap;
  logic                  full;
  logic                  flush;
  logic                  pop_ok;
  logic                  push;
  logic                  drop;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] wr_ptr_next;
  logic [ADDR_WIDTH-1:0] rd_ptr_next;
  logic [CNT_W-1:0]      count_next;
  logic                  tx_ovf_next;
  logic                  thre_evt_next;
  logic                  temt_next;

  // Occupancy decode and push/pop/drop arbitration; a flush overrides any same-cycle traffic
  always_comb begin
    cap    = fifo_en_q ? CNT_W'(DEPTH) : CNT_W'(1);
    full   = (count == cap);
    flush  = bus.tx_fifo_clr | (bus.fifo_en != fifo_en_q);
    pop_ok = bus.tsr_load & (count != '0);
    push   = bus.wr_en & (~full | pop_ok);
    drop   = bus.wr_en & full & ~pop_ok;
    mem_we = presetn & ~flush & push;
  end

  // Next-state values for pointers, count and status flags
  always_comb begin
    wr_ptr_next   = wr_ptr;
    rd_ptr_next   = rd_ptr;
    count_next    = count;
    tx_ovf_next   = tx_ovf_q;
    thre_evt_next = 1'b0;

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
      tx_ovf_next = 1'b0;
    end else begin
      // Single-slot mode keeps both pointers parked on entry 0
      if (push) begin
        wr_ptr_next = fifo_en_q ? (wr_ptr + ADDR_WIDTH'(1)) : '0;
      end
      if (pop_ok) begin
        rd_ptr_next = fifo_en_q ? (rd_ptr + ADDR_WIDTH'(1)) : '0;
      end
      if (push && !pop_ok) begin
        count_next = count + CNT_W'(1);
      end else if (pop_ok && !push) begin
        count_next = count - CNT_W'(1);
      end
      if (drop) begin
        tx_ovf_next = 1'b1;
      end
      // Only a real pop draining the last entry raises the THRE event
      thre_evt_next = pop_ok & ~push & (count == CNT_W'(1));
    end

    temt_next = (count_next == '0) & bus.not_op;
  end

  // Control/status registers with synchronous active-low reset
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tx_ovf_q   <= 1'b0;
      thre_evt_q <= 1'b0;
      temt_q     <= 1'b1;
      fifo_en_q  <= bus.fifo_en;
    end else begin
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      count      <= count_next;
      tx_ovf_q   <= tx_ovf_next;
      thre_evt_q <= thre_evt_next;
      temt_q     <= temt_next;
      fifo_en_q  <= bus.fifo_en;
    end
  end

  // Character storage; contents need no reset since thr_data is qualified by thre
  always_ff @(posedge pclk) begin
    if (mem_we) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Head entry falls through combinationally; status derives from registered state
  always_comb begin
    bus.thr_data = mem[rd_ptr];
    bus.thre     = (count == '0);
    bus.temt     = temt_q;
    bus.tx_level = count;
    bus.tx_ovf   = tx_ovf_q;
    bus.thre_evt = thre_evt_q;
  end

endmodule
